pc_gen: RTL

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC register with a block that has a configurable width, reset vector and instruction step. It adds a sticky halt/resume state machine and an optional return-address stack (RAS) for call/return redirects. It sits ahead of instruction memory and feeds o_pc to the fetch address and o_pc_next to the IF/ID register.

---
 rtl/pc_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-stage program counter with halt/resume FSM and optional return-address stack.
//   Optional RAS is built only when PC_GEN_RAS_EN is defined.
//   i_clk, i_reset_n         : clock, async active-low reset
//   i_jump, i_jump_addr      : redirect request and target
//   i_call, i_ret            : call (qualifies i_jump, pushes return address), return (pops RAS)
//   i_stall, i_halt, i_resume: hold this cycle, enter halted, leave halted
//   o_pc, o_pc_next          : current fetch PC and PC + INSTR_BYTES
//   o_halted                 : halted state
//   o_ras_empty/full         : RAS occupancy status
//   o_ras_overflow/miss      : one-cycle pulses for push-while-full and ret-while-empty
module pc_gen #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_addr,
    input  logic            i_call,
    input  logic            i_ret,
    input  logic            i_stall,
    input  logic            i_halt,
    input  logic            i_resume,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_next,
    output logic            o_halted,
    output logic            o_ras_empty,
    output logic            o_ras_full,
    output logic            o_ras_overflow,
    output logic            o_ras_miss
);
    localparam logic [PC_W-1:0] STEP       = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - PC_W'(1));
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nxt;
    logic active;
    logic [PC_W-1:0] pc_d;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) state <= RUN;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == RUN && i_halt) state_nxt = HALTED;
        else if (state == HALTED && i_resume && !i_halt) state_nxt = RUN;
    end
    assign o_halted = state == HALTED;
    // halt takes effect on the very edge that samples it
    assign active = state == RUN && !i_halt && !i_stall;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            o_pc      <= RESET_VECTOR;
            o_pc_next <= RESET_VECTOR + STEP;
        end else if (active) begin
            o_pc      <= pc_d;
            o_pc_next <= pc_d + STEP;
        end
`ifdef PC_GEN_RAS_EN
    localparam int SP_W = $clog2(RAS_DEPTH);
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [SP_W-1:0] sp, top_idx;
    logic [SP_W:0] cnt;
    logic do_push, do_pop, miss;
    assign o_ras_empty = cnt == '0;
    assign o_ras_full  = cnt == (SP_W+1)'(RAS_DEPTH);
    assign top_idx     = sp - SP_W'(1);
    assign do_pop      = i_ret && !o_ras_empty;
    assign miss        = i_ret && o_ras_empty;
    // a ret always wins over a call, even when the ret misses
    assign do_push     = !i_ret && i_jump && i_call;
    assign pc_d = do_pop ? ras[top_idx] & ALIGN_MASK : i_jump ? i_jump_addr & ALIGN_MASK : o_pc_next;
    // sp is the next write slot; when full it points at the oldest entry, so a push overwrites it
    always_ff @(posedge i_clk)
        if (active && do_push) ras[sp] <= o_pc_next;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            sp             <= '0;
            cnt            <= '0;
            o_ras_overflow <= 1'b0;
            o_ras_miss     <= 1'b0;
        end else begin
            o_ras_overflow <= active && do_push && o_ras_full;
            o_ras_miss     <= active && miss;
            if (active && do_push) begin
                sp  <= sp + SP_W'(1);
                cnt <= o_ras_full ? cnt : cnt + (SP_W+1)'(1);
            end else if (active && do_pop) begin
                sp  <= top_idx;
                cnt <= cnt - (SP_W+1)'(1);
            end
        end
`else
    logic unused_ras;
    assign unused_ras     = ^{i_call, i_ret};
    assign pc_d           = i_jump ? i_jump_addr & ALIGN_MASK : o_pc_next;
    assign o_ras_empty    = 1'b1;
    assign o_ras_full     = 1'b0;
    assign o_ras_overflow = 1'b0;
    assign o_ras_miss     = 1'b0;
`endif
endmodule
